axi4_lite_regfile_v3: RTL and testbench

// - Parametrised AXI4-Lite slave register file; next generation of the v2 wrapper.
// - Generalises register count and data width, adds byte strobes, read-only (hardware-fed) registers
//   and SLVERR decoding. Sits behind the AXI VIP/interconnect in the block design and exports

---
 rtl/axi4_lite_regfile_v3.sv | 225 ++++++++++++++++++++++
 tb/tb_axi4_lite_regfile_v3.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_regfile_v3.sv
// AXI4-Lite slave register file with byte strobes, hardware-fed read-only registers and SLVERR decode.
// Optional per-register write pulse output enabled by defining AXI_REGFILE_WR_PULSE_EN.
module axi4_lite_regfile_v3 #(
   parameter int unsigned          REGISTERS  = 4,
   parameter int unsigned          DATA_WIDTH = 32,
   parameter int unsigned          ADDR_WIDTH = 12,
   parameter logic [REGISTERS-1:0] RO_MASK    = '0
) (
   input  logic                            aclk,
   input  logic                            areset,
   input  logic [ADDR_WIDTH-1:0]           s_awaddr,
   input  logic                            s_awvalid,
   output logic                            s_awready,
   input  logic [DATA_WIDTH-1:0]           s_wdata,
   input  logic [DATA_WIDTH/8-1:0]         s_wstrb,
   input  logic                            s_wvalid,
   output logic                            s_wready,
   output logic [1:0]                      s_bresp,
   output logic                            s_bvalid,
   input  logic                            s_bready,
   input  logic [ADDR_WIDTH-1:0]           s_araddr,
   input  logic                            s_arvalid,
   output logic                            s_arready,
   output logic [DATA_WIDTH-1:0]           s_rdata,
   output logic [1:0]                      s_rresp,
   output logic                            s_rvalid,
   input  logic                            s_rready,
   output logic [REGISTERS*DATA_WIDTH-1:0] reg_out,
`ifdef AXI_REGFILE_WR_PULSE_EN
   output logic [REGISTERS-1:0]            reg_wr_pulse,
`endif
   input  logic [REGISTERS*DATA_WIDTH-1:0] reg_in
);

   localparam int unsigned STRB_W   = DATA_WIDTH / 8;
   localparam int unsigned ADDR_LSB = $clog2(STRB_W);
   localparam int unsigned IDX_W    = ADDR_WIDTH - ADDR_LSB;
   localparam int unsigned RIDX_W   = (REGISTERS > 1) ? $clog2(REGISTERS) : 1;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_t;
   typedef enum logic {R_IDLE, R_RESP} rstate_t;

   wstate_t wstate;
   rstate_t rstate;

   logic [DATA_WIDTH-1:0] regs [REGISTERS];
   logic [IDX_W-1:0]      aw_idx_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [STRB_W-1:0]     wstrb_q;

   logic aw_hs, w_hs, ar_hs;
   assign aw_hs = s_awvalid & s_awready;
   assign w_hs  = s_wvalid & s_wready;
   assign ar_hs = s_arvalid & s_arready;

   // Only the word index matters; byte-offset address bits are intentionally ignored.
   logic unused_addr_bits;
   assign unused_addr_bits = &{1'b0, s_awaddr[ADDR_LSB-1:0], s_araddr[ADDR_LSB-1:0]};

   function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
      return (32'(idx) < REGISTERS);
   endfunction

   function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0] old_val,
                                                         input logic [DATA_WIDTH-1:0] new_val,
                                                         input logic [STRB_W-1:0]     strb);
      logic [DATA_WIDTH-1:0] res;
      res = old_val;
      for (int b = 0; b < int'(STRB_W); b++) begin
         if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
      end
      return res;
   endfunction

   // Select the address/data pair that commits on this edge, whichever channel arrived last.
   logic                  commit_c;
   logic                  commit_ok_c;
   logic [IDX_W-1:0]      cidx_c;
   logic [RIDX_W-1:0]     cridx_c;
   logic [DATA_WIDTH-1:0] cdata_c;
   logic [STRB_W-1:0]     cstrb_c;

   always_comb begin
      commit_c = 1'b0;
      cidx_c   = s_awaddr[ADDR_WIDTH-1:ADDR_LSB];
      cdata_c  = s_wdata;
      cstrb_c  = s_wstrb;
      case (wstate)
         W_IDLE:    commit_c = aw_hs & w_hs;
         W_HAVE_AW: begin
            commit_c = w_hs;
            cidx_c   = aw_idx_q;
         end
         W_HAVE_W:  begin
            commit_c = aw_hs;
            cdata_c  = wdata_q;
            cstrb_c  = wstrb_q;
         end
         default:   commit_c = 1'b0;
      endcase
      cridx_c     = RIDX_W'(cidx_c);
      commit_ok_c = idx_in_range(cidx_c) && !RO_MASK[cridx_c];
   end

   logic [IDX_W-1:0]  ar_idx_c;
   logic [RIDX_W-1:0] ar_ridx_c;
   logic              ar_ok_c;
   assign ar_idx_c  = s_araddr[ADDR_WIDTH-1:ADDR_LSB];
   assign ar_ridx_c = RIDX_W'(ar_idx_c);
   assign ar_ok_c   = idx_in_range(ar_idx_c);

   // Register storage; read-only slots are never written and stay at zero.
   always_ff @(posedge aclk) begin
      if (areset) begin
         for (int i = 0; i < int'(REGISTERS); i++) regs[i] <= '0;
      end else if (commit_c && commit_ok_c) begin
         regs[cridx_c] <= merge_bytes(regs[cridx_c], cdata_c, cstrb_c);
      end
   end

   for (genvar g = 0; g < int'(REGISTERS); g++) begin : g_reg_out
      assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[g] ? '0 : regs[g];
   end

   // Write channel FSM.
   always_ff @(posedge aclk) begin
      if (areset) begin
         wstate    <= W_IDLE;
         s_awready <= 1'b0;
         s_wready  <= 1'b0;
         s_bvalid  <= 1'b0;
         s_bresp   <= RESP_OKAY;
         aw_idx_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
      end else begin
         case (wstate)
            W_IDLE: begin
               s_awready <= 1'b1;
               s_wready  <= 1'b1;
               if (aw_hs && !w_hs) begin
                  aw_idx_q  <= s_awaddr[ADDR_WIDTH-1:ADDR_LSB];
                  s_awready <= 1'b0;
                  wstate    <= W_HAVE_AW;
               end else if (w_hs && !aw_hs) begin
                  wdata_q  <= s_wdata;
                  wstrb_q  <= s_wstrb;
                  s_wready <= 1'b0;
                  wstate   <= W_HAVE_W;
               end
            end
            W_HAVE_AW, W_HAVE_W: ;
            W_RESP: begin
               if (s_bready) begin
                  s_bvalid  <= 1'b0;
                  s_awready <= 1'b1;
                  s_wready  <= 1'b1;
                  wstate    <= W_IDLE;
               end
            end
            default: wstate <= W_IDLE;
         endcase
         if (commit_c) begin
            s_bvalid  <= 1'b1;
            s_bresp   <= commit_ok_c ? RESP_OKAY : RESP_SLVERR;
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
            wstate    <= W_RESP;
         end
      end
   end

   // Read channel FSM; rdata is captured before any same-edge write lands.
   always_ff @(posedge aclk) begin
      if (areset) begin
         rstate    <= R_IDLE;
         s_arready <= 1'b0;
         s_rvalid  <= 1'b0;
         s_rresp   <= RESP_OKAY;
         s_rdata   <= '0;
      end else begin
         case (rstate)
            R_IDLE: begin
               s_arready <= 1'b1;
               if (ar_hs) begin
                  s_arready <= 1'b0;
                  s_rvalid  <= 1'b1;
                  rstate    <= R_RESP;
                  if (!ar_ok_c) begin
                     s_rdata <= '0;
                     s_rresp <= RESP_SLVERR;
                  end else begin
                     s_rdata <= RO_MASK[ar_ridx_c] ? reg_in[DATA_WIDTH*ar_ridx_c +: DATA_WIDTH]
                                                   : regs[ar_ridx_c];
                     s_rresp <= RESP_OKAY;
                  end
               end
            end
            R_RESP: begin
               if (s_rready) begin
                  s_rvalid  <= 1'b0;
                  s_arready <= 1'b1;
                  rstate    <= R_IDLE;
               end
            end
            default: rstate <= R_IDLE;
         endcase
      end
   end

`ifdef AXI_REGFILE_WR_PULSE_EN
   // One-cycle strobe per successful commit, independent of the byte strobes.
   always_ff @(posedge aclk) begin
      if (areset) begin
         reg_wr_pulse <= '0;
      end else begin
         reg_wr_pulse <= '0;
         if (commit_c && commit_ok_c) reg_wr_pulse[cridx_c] <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_axi4_lite_regfile_v3.sv
// Self-checking bench for axi4_lite_regfile_v3: directed scenarios plus randomized traffic
// checked against an array-based register model.
module tb_axi4_lite_regfile_v3;

   localparam logic [3:0] RO = 4'b1000;

   logic         aclk = 1'b0;
   logic         areset;
   logic [11:0]  s_awaddr;
   logic         s_awvalid;
   logic         s_awready;
   logic [31:0]  s_wdata;
   logic [3:0]   s_wstrb;
   logic         s_wvalid;
   logic         s_wready;
   logic [1:0]   s_bresp;
   logic         s_bvalid;
   logic         s_bready;
   logic [11:0]  s_araddr;
   logic         s_arvalid;
   logic         s_arready;
   logic [31:0]  s_rdata;
   logic [1:0]   s_rresp;
   logic         s_rvalid;
   logic         s_rready;
   logic [127:0] reg_out;
   logic [127:0] reg_in;
`ifdef AXI_REGFILE_WR_PULSE_EN
   logic [3:0]   reg_wr_pulse;
`endif

   axi4_lite_regfile_v3 #(
      .REGISTERS(4), .DATA_WIDTH(32), .ADDR_WIDTH(12), .RO_MASK(RO)
   ) dut (
      .aclk(aclk), .areset(areset),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .reg_out(reg_out),
`ifdef AXI_REGFILE_WR_PULSE_EN
      .reg_wr_pulse(reg_wr_pulse),
`endif
      .reg_in(reg_in)
   );

   always #5 aclk = ~aclk;

   int checks = 0;
   int failures = 0;
   int exp_pulses = 0;
   logic [31:0] mdl [4];

`ifdef AXI_REGFILE_WR_PULSE_EN
   int pulse_cnt = 0;
   always @(negedge aclk) pulse_cnt += $countones(reg_wr_pulse);
`endif

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] exp_reg_out();
      logic [127:0] v;
      for (int i = 0; i < 4; i++) v[i*32 +: 32] = RO[i] ? 32'h0 : mdl[i];
      return v;
   endfunction

   function automatic logic [31:0] apply_strb(input logic [31:0] old_val, input logic [31:0] d,
                                              input logic [3:0] strb);
      logic [31:0] v;
      v = old_val;
      for (int b = 0; b < 4; b++) if (strb[b]) v[b*8 +: 8] = d[b*8 +: 8];
      return v;
   endfunction

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   // Full AW+W write with bready high; checks response timing, commit, and optional pulse.
   task automatic do_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb);
      int unsigned idx;
      logic        ok;
      int          n;
      idx = 32'(addr) >> 2;
      ok  = (idx < 4) && !RO[idx[1:0]];
      s_awaddr = addr; s_awvalid = 1'b1;
      s_wdata = data; s_wstrb = strb; s_wvalid = 1'b1; s_bready = 1'b1;
      n = 0;
      while (!(s_awready && s_wready) && n < 20) begin tick(); n++; end
      check("wr_accept_timeout", 128'(n >= 20), 128'(0));
      tick();
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      if (ok) begin
         mdl[idx[1:0]] = apply_strb(mdl[idx[1:0]], data, strb);
         exp_pulses++;
      end
      check("wr_bvalid", 128'(s_bvalid), 128'(1));
      check("wr_bresp", 128'(s_bresp), ok ? 128'(0) : 128'(2));
      check("wr_reg_out", reg_out, exp_reg_out());
`ifdef AXI_REGFILE_WR_PULSE_EN
      check("wr_pulse", 128'(reg_wr_pulse), ok ? 128'(4'(1 << idx[1:0])) : 128'(0));
`endif
      tick();
      check("wr_bvalid_clear", 128'(s_bvalid), 128'(0));
   endtask

   task automatic do_read(input logic [11:0] addr);
      int unsigned idx;
      logic [31:0] ed;
      logic [1:0]  er;
      int          n;
      idx = 32'(addr) >> 2;
      if (idx >= 4) begin ed = 32'h0; er = 2'b10; end
      else if (RO[idx[1:0]]) begin ed = reg_in[idx[1:0]*32 +: 32]; er = 2'b00; end
      else begin ed = mdl[idx[1:0]]; er = 2'b00; end
      s_araddr = addr; s_arvalid = 1'b1; s_rready = 1'b1;
      n = 0;
      while (!s_arready && n < 20) begin tick(); n++; end
      check("rd_accept_timeout", 128'(n >= 20), 128'(0));
      tick();
      s_arvalid = 1'b0;
      check("rd_rvalid", 128'(s_rvalid), 128'(1));
      check("rd_rdata", 128'(s_rdata), 128'(ed));
      check("rd_rresp", 128'(s_rresp), 128'(er));
      tick();
      check("rd_rvalid_clear", 128'(s_rvalid), 128'(0));
   endtask

   initial begin
      logic [31:0] old1;
      areset = 1'b1;
      s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
      s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
      reg_in = '0;
      for (int i = 0; i < 4; i++) mdl[i] = 32'h0;

      // Reset state
      repeat (3) tick();
      check("rst_awready", 128'(s_awready), 128'(0));
      check("rst_wready", 128'(s_wready), 128'(0));
      check("rst_arready", 128'(s_arready), 128'(0));
      check("rst_bvalid", 128'(s_bvalid), 128'(0));
      check("rst_rvalid", 128'(s_rvalid), 128'(0));
      check("rst_resp", 128'({s_bresp, s_rresp}), 128'(0));
      check("rst_rdata", 128'(s_rdata), 128'(0));
      check("rst_reg_out", reg_out, 128'(0));
      areset = 1'b0;
      tick();
      check("post_rst_ready", 128'({s_awready, s_wready, s_arready}), 128'(3'b111));

      // Sequential values into the RW registers
      for (int i = 0; i < 3; i++) do_write(12'(i * 4), 32'(i), 4'hF);
      for (int i = 0; i < 3; i++) do_read(12'(i * 4));
      check("seq_reg_out", 128'(reg_out[95:0]), 128'({32'd2, 32'd1, 32'd0}));

      // Out-of-range index
      do_write(12'h010, 32'hDEAD_BEEF, 4'hF);
      do_read(12'h010);

      // Read-only register: write rejected, read returns hardware value
      reg_in[127:96] = 32'hCAFE_0003;
      do_write(12'h00C, 32'hFFFF_FFFF, 4'hF);
      do_read(12'h00C);
      check("ro_reg_out_zero", 128'(reg_out[127:96]), 128'(0));

      // Byte strobes
      do_write(12'h000, 32'h1122_3344, 4'hF);
      do_write(12'h000, 32'hAABB_CCDD, 4'b0101);
      do_read(12'h000);
      check("strb_value", 128'(mdl[0]), 128'(32'h11BB_33DD));

      // W ahead of AW by three cycles, then bready stalled for five cycles
      s_bready = 1'b0;
      s_wdata = 32'h0BAD_F00D; s_wstrb = 4'hF; s_wvalid = 1'b1;
      tick();
      s_wvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("early_w_wready", 128'(s_wready), 128'(0));
         check("early_w_awready", 128'(s_awready), 128'(1));
         check("early_w_no_commit", 128'({s_bvalid, reg_out[63:32]}), 128'({1'b0, mdl[1]}));
         tick();
      end
      s_awaddr = 12'h004; s_awvalid = 1'b1;
      tick();
      s_awvalid = 1'b0;
      mdl[1] = 32'h0BAD_F00D;
      exp_pulses++;
      check("early_w_commit", reg_out, exp_reg_out());
      for (int i = 0; i < 5; i++) begin
         check("stall_b", 128'({s_bvalid, s_bresp, s_awready, s_wready}), 128'({1'b1, 2'b00, 1'b0, 1'b0}));
         tick();
      end
      s_bready = 1'b1;
      tick();
      check("stall_b_release", 128'(s_bvalid), 128'(0));
      check("stall_single_commit", reg_out, exp_reg_out());

      // Same-edge write and read of one register: read sees the old value
      old1 = mdl[1];
      s_awaddr = 12'h004; s_wdata = 32'h5A5A_0001; s_wstrb = 4'hF;
      s_awvalid = 1'b1; s_wvalid = 1'b1; s_araddr = 12'h004; s_arvalid = 1'b1;
      s_bready = 1'b1; s_rready = 1'b1;
      tick();
      s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
      mdl[1] = 32'h5A5A_0001;
      exp_pulses++;
      check("same_edge_rdata", 128'(s_rdata), 128'(old1));
      check("same_edge_valids", 128'({s_bvalid, s_rvalid}), 128'(2'b11));
      check("same_edge_reg_out", reg_out, exp_reg_out());
      tick();

      // Reset while only AW is latched: nothing commits, then a normal write works
      s_awaddr = 12'h008; s_awvalid = 1'b1; s_bready = 1'b1;
      tick();
      s_awvalid = 1'b0;
      areset = 1'b1;
      tick();
      areset = 1'b0;
      for (int i = 0; i < 4; i++) mdl[i] = 32'h0;
      check("mid_rst_bvalid", 128'(s_bvalid), 128'(0));
      check("mid_rst_reg_out", reg_out, 128'(0));
      s_wdata = 32'h7777_7777; s_wstrb = 4'hF; s_wvalid = 1'b1;
      tick();
      s_wvalid = 1'b0;
      check("mid_rst_no_late_commit", 128'({s_bvalid, reg_out}), 128'({1'b0, 128'(0)}));
      tick();
      check("mid_rst_ready", 128'({s_awready, s_wready}), 128'(2'b11));
      do_write(12'h008, 32'h1234_5678, 4'hF);
      do_read(12'h008);

      // Randomized traffic against the model
      for (int t = 0; t < 200; t++) begin
         logic [11:0] a;
         if ($urandom_range(0, 9) == 0) a = 12'h400 | 12'($urandom_range(0, 3));
         else a = 12'($urandom_range(0, 5) << 2) | 12'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) reg_in = {$urandom, $urandom, $urandom, $urandom};
         if ($urandom_range(0, 1) == 0) do_write(a, $urandom, 4'($urandom_range(0, 15)));
         else do_read(a);
      end
      check("final_reg_out", reg_out, exp_reg_out());

`ifdef AXI_REGFILE_WR_PULSE_EN
      tick();
      check("pulse_total", 128'(pulse_cnt), 128'(exp_pulses));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
